// File: rtl/act_lut_pkg.sv
// act_lut_pkg: shared widths and the reset (ReLU) contents of the activation table.
//   DATA_W  : width of x, table samples and fetch outputs
//   FRAC_W  : low bits of x carried as the interpolation remainder
//   IDX_W   : table index width (DATA_W - FRAC_W)
//   ENTRIES : table depth, derived from IDX_W
package act_lut_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned FRAC_W  = 4;
  localparam int unsigned IDX_W   = DATA_W - FRAC_W;
  localparam int unsigned ENTRIES = 2 ** IDX_W;

  // ReLU sample at entry i; entry ENTRIES/2 corresponds to x = 0
  function automatic logic signed [DATA_W-1:0] relu_init(input int unsigned i);
    int v;
    v = (int'(i) - int'(ENTRIES / 2)) * int'(2 ** FRAC_W);
    return (v > 0) ? DATA_W'(v) : '0;
  endfunction

endpackage

// File: rtl/act_lut_table.sv
// act_lut_table: activation sample store with two asynchronous read ports.
//   Optional build macro ACT_LUT_WRITE_EN:
//     defined   -> register file, reset to ReLU samples, one synchronous write port
//                  (clk, rst active-low synchronous, wr_en, wr_addr, wr_data)
//     undefined -> constant ReLU ROM, no clock or write ports
//   rd_addr_a / rd_data_a : base sample read
//   rd_addr_b / rd_data_b : neighbour sample read
module act_lut_table
  import act_lut_pkg::*;
(
`ifdef ACT_LUT_WRITE_EN
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [IDX_W-1:0]         wr_addr,
  input  logic signed [DATA_W-1:0] wr_data,
`endif
  input  logic [IDX_W-1:0]         rd_addr_a,
  input  logic [IDX_W-1:0]         rd_addr_b,
  output logic signed [DATA_W-1:0] rd_data_a,
  output logic signed [DATA_W-1:0] rd_data_b
);

`ifdef ACT_LUT_WRITE_EN
  logic signed [DATA_W-1:0] mem [ENTRIES];

  // Reset has priority over a concurrent write; reads see pre-edge contents
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        mem[i] <= relu_init(i);
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a = mem[rd_addr_a];
  assign rd_data_b = mem[rd_addr_b];
`else
  // Constant ReLU ROM
  always_comb begin
    rd_data_a = relu_init(32'(rd_addr_a));
    rd_data_b = relu_init(32'(rd_addr_b));
  end
`endif

endmodule

// File: rtl/act_lut_fetch.sv
// act_lut_fetch: front stage of the activation unit. Splits signed x into a table index
// and a fractional remainder, then fetches the two neighbouring table samples.
// Two-stage valid/ready pipeline (stage 1 holds x, stage 2 holds the fetch results).
//   clk, rst (synchronous, active-low)
//   in_valid/in_ready/x                      : upstream handshake and pre-activation value
//   out_valid/out_ready                      : downstream handshake
//   base/next_data/remaining                 : table[idx], table[min(idx+1,15)], x[3:0]
//   wr_en/wr_addr/wr_data                    : table write, present only with ACT_LUT_WRITE_EN
module act_lut_fetch
  import act_lut_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] x,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] base,
  output logic signed [DATA_W-1:0] next_data,
  output logic signed [DATA_W-1:0] remaining
`ifdef ACT_LUT_WRITE_EN
  ,
  input  logic                     wr_en,
  input  logic [IDX_W-1:0]         wr_addr,
  input  logic signed [DATA_W-1:0] wr_data
`endif
);

  logic                     s1_valid;
  logic signed [DATA_W-1:0] s1_x;
  logic                     s1_load;
  logic                     s2_load;
  logic [IDX_W-1:0]         idx;
  logic [IDX_W-1:0]         idx_next;
  logic signed [DATA_W-1:0] rd_base;
  logic signed [DATA_W-1:0] rd_next;

  // Handshake: in_ready is combinational from out_ready by design
  always_comb begin
    s2_load  = !out_valid || out_ready;
    s1_load  = !s1_valid || s2_load;
    in_ready = s1_load;
  end

  // Offset-binary index (flip the sign bit) and clamped neighbour index
  always_comb begin
    idx      = {~s1_x[DATA_W-1], s1_x[DATA_W-2:FRAC_W]};
    idx_next = (idx == IDX_W'(ENTRIES - 1)) ? idx : idx + IDX_W'(1);
  end

  act_lut_table u_table (
`ifdef ACT_LUT_WRITE_EN
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
`endif
    .rd_addr_a (idx),
    .rd_addr_b (idx_next),
    .rd_data_a (rd_base),
    .rd_data_b (rd_next)
  );

  // Stage 1: capture x
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_x <= x;
      end
    end
  end

  // Stage 2: register the fetched samples and the unsigned remainder
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      base      <= '0;
      next_data <= '0;
      remaining <= '0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        base      <= rd_base;
        next_data <= rd_next;
        remaining <= {{(DATA_W - FRAC_W){1'b0}}, s1_x[FRAC_W-1:0]};
      end
    end
  end

endmodule
